// File: rtl/icache_nway_ctrl.sv
// N-way set-associative instruction cache controller with true-LRU replacement,
// a single-beat refill handshake to main memory, flush, and saturating hit/miss counters.
module icache_nway_ctrl #(
  parameter int WAYS  = 2,
  parameter int SETS  = 4,
  parameter int WORDS = 2,
  parameter int CNT_W = 20
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [31:0]           PC,
  input  logic                  PC_VALID,
  input  logic                  FLUSH,
  output logic                  MM_REQ,
  output logic [31:0]           MM_ADDR,
  input  logic                  MM_VALID,
  input  logic [32*WORDS-1:0]   MM_DATA,
  output logic                  HIT_WRITE,
  output logic [31:0]           INST,
  output logic [CNT_W-1:0]      CNT_HIT,
  output logic [CNT_W-1:0]      CNT_MISS,
  output logic [1:0]            DBG_STATE
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Refill handshake: MM_REQ is held high from the miss edge until the first
  // cycle MM_VALID is sampled high in REQ; that edge consumes MM_DATA.
  // MM_VALID outside REQ carries no meaning and is ignored.

  logic [1:0]             state;
  logic [SETS-1:0]        valid_q [WAYS];
  logic [TAG_W-1:0]       tag_q   [WAYS][SETS];
  logic [31:0]            data_q  [WAYS][SETS][WORDS];
  logic [AGE_W-1:0]       age_q   [SETS][WAYS];
  logic [IDX_W-1:0]       miss_idx;
  logic [TAG_W-1:0]       miss_tag;
  logic                   replay;
  logic [31:0]            last_pc;

  logic [OFF_W-1:0]       pc_off;
  logic [IDX_W-1:0]       pc_idx;
  logic [TAG_W-1:0]       pc_tag;
  logic                   hit;
  logic [AGE_W-1:0]       hit_way;
  logic [AGE_W-1:0]       victim;
  logic                   victim_found;
  logic                   lookup_hit;
  logic                   refill_fire;
  logic                   lru_en;
  logic [IDX_W-1:0]       lru_idx;
  logic [AGE_W-1:0]       lru_way;
  logic [AGE_W-1:0]       acc_age;
  logic [AGE_W-1:0]       lru_next [WAYS];
  logic                   unused_pc_bits;

  assign pc_off         = PC[OFF_W+1:2];
  assign pc_idx         = PC[IDX_W+OFF_W+1:OFF_W+2];
  assign pc_tag         = PC[31:IDX_W+OFF_W+2];
  assign unused_pc_bits = ^PC[1:0];
  assign DBG_STATE      = state;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][pc_idx] && (tag_q[w][pc_idx] == pc_tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  // Lowest invalid way first, otherwise the oldest way of the latched set.
  always_comb begin
    victim       = '0;
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid_q[w][miss_idx]) begin
        victim       = AGE_W'(w);
        victim_found = 1'b1;
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[miss_idx][w] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
      end
    end
  end

  assign lookup_hit  = (state == ST_IDLE) && !FLUSH && PC_VALID && hit;
  assign refill_fire = (state == ST_REQ) && MM_VALID;

  always_comb begin
    lru_en  = 1'b0;
    lru_idx = pc_idx;
    lru_way = hit_way;
    if (refill_fire) begin
      lru_en  = 1'b1;
      lru_idx = miss_idx;
      lru_way = victim;
    end else if (lookup_hit) begin
      lru_en = 1'b1;
    end
    acc_age = age_q[lru_idx][lru_way];
    for (int w = 0; w < WAYS; w++) begin
      lru_next[w] = age_q[lru_idx][w];
      if (AGE_W'(w) == lru_way) lru_next[w] = '0;
      else if (age_q[lru_idx][w] < acc_age) lru_next[w] = age_q[lru_idx][w] + 1'b1;
    end
  end

  // Hit data is returned in the same cycle as the lookup.
  always_comb begin
    HIT_WRITE = 1'b0;
    INST      = '0;
    if (!RESET_N) begin
      HIT_WRITE = 1'b1;
    end else if (state == ST_IDLE) begin
      if (FLUSH) begin
        HIT_WRITE = 1'b0;
      end else if (!PC_VALID) begin
        HIT_WRITE = 1'b1;
      end else if (hit) begin
        HIT_WRITE = 1'b1;
        INST      = data_q[hit_way][pc_idx][pc_off];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= ST_IDLE;
      MM_REQ   <= 1'b0;
      MM_ADDR  <= '0;
      miss_idx <= '0;
      miss_tag <= '0;
      CNT_HIT  <= '0;
      CNT_MISS <= '0;
      replay   <= 1'b0;
      last_pc  <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
    end else begin
      if (FLUSH)
        for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      if (lru_en)
        for (int w = 0; w < WAYS; w++) age_q[lru_idx][w] <= lru_next[w];
      case (state)
        ST_IDLE: begin
          if (!FLUSH && PC_VALID) begin
            if (hit) begin
              if ((PC != last_pc) && !replay && (CNT_HIT != '1)) CNT_HIT <= CNT_HIT + 1'b1;
              last_pc <= PC;
              replay  <= 1'b0;
            end else begin
              miss_idx <= pc_idx;
              miss_tag <= pc_tag;
              MM_ADDR  <= {PC[31:OFF_W+2], (OFF_W+2)'(0)};
              MM_REQ   <= 1'b1;
              if (CNT_MISS != '1) CNT_MISS <= CNT_MISS + 1'b1;
              state    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // Placed after the flush clear so a coincident refill stays valid.
          if (MM_VALID) begin
            valid_q[victim][miss_idx] <= 1'b1;
            MM_REQ <= 1'b0;
            replay <= 1'b1;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (refill_fire) begin
      tag_q[victim][miss_idx] <= miss_tag;
      for (int k = 0; k < WORDS; k++)
        data_q[victim][miss_idx][k] <= MM_DATA[32*(WORDS-k)-1 -: 32];
    end
  end

endmodule

// File: tb/tb_icache_nway_ctrl.sv
// Directed bench for icache_nway_ctrl: a driver issues fetches and serves refills,
// a negedge monitor pops expected instructions whenever a fetch is accepted.
module tb_icache_nway_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        mm_valid;
  logic [63:0] mm_data;
  logic        mm_req;
  logic [31:0] mm_addr;
  logic        hit_write;
  logic [31:0] inst;
  logic [19:0] cnt_hit;
  logic [19:0] cnt_miss;
  logic [1:0]  dbg_state;
  logic        s_mm_req;
  logic [31:0] s_mm_addr;
  logic        s_hit_write;
  logic [31:0] s_inst;
  logic [1:0]  s_cnt_hit;
  logic [1:0]  s_cnt_miss;
  logic [1:0]  s_dbg_state;

  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_errors;

  icache_nway_ctrl dut (
    .CLK(clk), .RESET_N(rst_n), .PC(pc), .PC_VALID(pc_valid), .FLUSH(flush),
    .MM_REQ(mm_req), .MM_ADDR(mm_addr), .MM_VALID(mm_valid), .MM_DATA(mm_data),
    .HIT_WRITE(hit_write), .INST(inst), .CNT_HIT(cnt_hit), .CNT_MISS(cnt_miss),
    .DBG_STATE(dbg_state)
  );

  icache_nway_ctrl #(.CNT_W(2)) dut_sat (
    .CLK(clk), .RESET_N(rst_n), .PC(pc), .PC_VALID(pc_valid), .FLUSH(flush),
    .MM_REQ(s_mm_req), .MM_ADDR(s_mm_addr), .MM_VALID(mm_valid), .MM_DATA(mm_data),
    .HIT_WRITE(s_hit_write), .INST(s_inst), .CNT_HIT(s_cnt_hit), .CNT_MISS(s_cnt_miss),
    .DBG_STATE(s_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && pc_valid && hit_write) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL inst: unexpected accept of pc %h, got %h expected nothing", pc, inst);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (inst !== e) begin
          n_errors++;
          $display("FAIL inst: pc %h got %h expected %h", pc, inst, e);
        end
      end
    end
  end

  // Driver: one accepted fetch per call; serves a refill after `delay` REQ cycles.
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input bit is_miss,
                       input int delay, input logic [63:0] refill, input bit flush_on_fill);
    int  waited;
    bit  done;
    exp_q.push_back(exp);
    pc       = a;
    pc_valid = 1'b1;
    waited   = 0;
    done     = 1'b0;
    for (int g = 0; g < 200 && !done; g++) begin
      @(negedge clk);
      if (mm_valid) begin
        mm_valid = 1'b0;
        flush    = 1'b0;
      end
      if (hit_write) begin
        done = 1'b1;
      end else if (mm_req) begin
        check("mm_addr", mm_addr, a & ~32'h7);
        waited++;
        if (waited > delay) begin
          mm_valid = 1'b1;
          mm_data  = refill;
          if (flush_on_fill) flush = 1'b1;
        end
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL fetch_timeout: pc %h got no accept expected accept", a);
      void'(exp_q.pop_back());
      mm_valid = 1'b0;
      flush    = 1'b0;
    end else begin
      check("req_cycles", 32'(waited), is_miss ? 32'(delay + 1) : 32'd0);
    end
    @(posedge clk);
    #1;
    pc_valid = 1'b0;
  endtask

  localparam logic [63:0] L100  = {32'hAAAA0000, 32'hBBBB1111};
  localparam logic [63:0] L140  = {32'h14000000, 32'h14011111};
  localparam logic [63:0] L180  = {32'h18000000, 32'h18011111};
  localparam logic [63:0] L200  = {32'h20000000, 32'h20011111};
  localparam logic [63:0] L300  = {32'h30000000, 32'h30011111};
  localparam logic [63:0] L100B = {32'hA1000000, 32'hA1011111};
  localparam logic [63:0] L148  = {32'h14800000, 32'h14811111};
  localparam logic [63:0] LATE  = {32'hDEAD0000, 32'hDEAD1111};

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    pc       = '0;
    pc_valid = 1'b0;
    flush    = 1'b0;
    mm_valid = 1'b0;
    mm_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hit_write", 32'(hit_write), 32'd1);
    check("rst_mm_req", 32'(mm_req), 32'd0);
    check("rst_mm_addr", mm_addr, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_cnt_hit", 32'(cnt_hit), 32'd0);
    check("rst_cnt_miss", 32'(cnt_miss), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First miss: combinational stall, then refill and replay
    pc = 32'h100;
    pc_valid = 1'b1;
    #1;
    check("miss_hit_write", 32'(hit_write), 32'd0);
    check("miss_inst", inst, 32'd0);
    fetch(32'h100, 32'hAAAA0000, 1, 0, L100, 0);
    check("cnt_miss_1", 32'(cnt_miss), 32'd1);
    check("cnt_hit_replay", 32'(cnt_hit), 32'd0);
    fetch(32'h104, 32'hBBBB1111, 0, 0, '0, 0);
    check("cnt_hit_1", 32'(cnt_hit), 32'd1);

    // Held PC counts a single hit
    for (int i = 0; i < 4; i++) fetch(32'h104, 32'hBBBB1111, 0, 0, '0, 0);
    check("cnt_hit_held", 32'(cnt_hit), 32'd1);

    // LRU replacement in set 0
    fetch(32'h140, 32'h14000000, 1, 1, L140, 0);
    fetch(32'h100, 32'hAAAA0000, 0, 0, '0, 0);
    fetch(32'h180, 32'h18000000, 1, 2, L180, 0);
    fetch(32'h100, 32'hAAAA0000, 0, 0, '0, 0);
    fetch(32'h140, 32'h14000000, 1, 0, L140, 0);
    check("cnt_miss_lru", 32'(cnt_miss), 32'd4);
    check("cnt_hit_lru", 32'(cnt_hit), 32'd3);

    // Long refill latency
    fetch(32'h200, 32'h20000000, 1, 10, L200, 0);
    check("cnt_miss_slow", 32'(cnt_miss), 32'd5);
    check("sat_cnt_miss_a", 32'(s_cnt_miss), 32'd3);
    check("sat_cnt_hit_a", 32'(s_cnt_hit), 32'd3);

    // Reset in the middle of a refill
    pc = 32'h300;
    pc_valid = 1'b1;
    @(negedge clk);
    check("rst_mid_stall", 32'(hit_write), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_req", 32'(mm_req), 32'd1);
      check("rst_mid_addr", mm_addr, 32'h300);
    end
    rst_n = 1'b0;
    pc_valid = 1'b0;
    #1;
    check("rst_mid_mm_req", 32'(mm_req), 32'd0);
    check("rst_mid_cnt_miss", 32'(cnt_miss), 32'd0);
    check("rst_mid_cnt_hit", 32'(cnt_hit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mm_valid = 1'b1;
    mm_data = LATE;
    @(negedge clk);
    mm_valid = 1'b0;
    check("late_valid_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;
    fetch(32'h300, 32'h30000000, 1, 0, L300, 0);
    check("late_cnt_miss", 32'(cnt_miss), 32'd1);

    // Flush coincident with a would-be hit
    fetch(32'h100, 32'hA1000000, 1, 0, L100B, 0);
    pc = 32'h104;
    pc_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_hit_write", 32'(hit_write), 32'd0);
    check("flush_inst", inst, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    pc_valid = 1'b0;
    check("flush_cnt_hit", 32'(cnt_hit), 32'd0);
    fetch(32'h100, 32'hA1000000, 1, 0, L100B, 0);
    check("flush_cnt_miss", 32'(cnt_miss), 32'd3);
    check("sat_cnt_miss_b", 32'(s_cnt_miss), 32'd3);

    // Flush together with refill: only the refilled line survives
    fetch(32'h148, 32'h14800000, 1, 0, L148, 1);
    fetch(32'h14C, 32'h14811111, 0, 0, '0, 0);
    check("fill_flush_hit", 32'(cnt_hit), 32'd1);
    fetch(32'h100, 32'hA1000000, 1, 0, L100B, 0);
    check("fill_flush_miss", 32'(cnt_miss), 32'd5);
    check("sat_cnt_miss_c", 32'(s_cnt_miss), 32'd3);

    repeat (2) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
